// File: rtl/input_handler.sv
// Pushbutton front end for the clock display.
// Five raw buttons are synchronised and debounced. Each press becomes a
// registered one-cycle command strobe. up/down auto-repeat while held.
// left/right move a one-hot field cursor.
// Command interface: up, down and reset are one-cycle strobes with no
// back-pressure. The consumer must act on every cycle in which a strobe is high.
module input_handler #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnReset,
  output logic       up,
  output logic       down,
  output logic       reset,
  output logic [2:0] cursorPos,
  output logic [1:0] upRepeatState,
  output logic [1:0] downRepeatState
);

  localparam int NB        = 5;
  localparam int IDX_UP    = 0;
  localparam int IDX_DOWN  = 1;
  localparam int IDX_LEFT  = 2;
  localparam int IDX_RIGHT = 3;
  localparam int IDX_RESET = 4;

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RDW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int RPW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int HW  = (RDW > RPW) ? RDW : RPW;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  RD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0]  RP_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeatState_e;

  logic [NB-1:0]  btnRaw;
  logic [NB-1:0]  sync1;
  logic [NB-1:0]  sync2;
  logic [NB-1:0]  level;
  logic [DBW-1:0] dbCnt [NB];
  logic [NB-1:0]  levelQ;
  logic [NB-1:0]  pressQ;

  repeatState_e   state       [2];
  repeatState_e   stateNext   [2];
  logic [HW-1:0]  holdCnt     [2];
  logic [HW-1:0]  holdCntNext [2];
  logic [1:0]     fire;
  logic           bothHeld;
  logic [2:0]     cursorNext;

  assign btnRaw = {btnReset, btnRight, btnLeft, btnDown, btnUp};

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btnRaw;
      sync2 <= sync1;
    end
  end

  // Debouncer: the level flips only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < NB; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != level[i]) begin
          if (dbCnt[i] == DB_LAST) begin
            level[i] <= ~level[i];
            dbCnt[i] <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 1'b1;
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect. levelQ stays aligned with pressQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      levelQ <= '0;
      pressQ <= '0;
    end else begin
      levelQ <= level;
      pressQ <= level & ~levelQ;
    end
  end

  // Auto-repeat next state. Index 0 is up and index 1 is down.
  // If both buttons are held, both machines are parked in IDLE.
  always_comb begin
    bothHeld = levelQ[IDX_UP] & levelQ[IDX_DOWN];
    fire     = '0;
    for (int d = 0; d < 2; d++) begin
      stateNext[d]   = state[d];
      holdCntNext[d] = holdCnt[d];
      if (bothHeld) begin
        stateNext[d]   = IDLE;
        holdCntNext[d] = '0;
      end else if (pressQ[d]) begin
        stateNext[d]   = DELAY;
        holdCntNext[d] = '0;
        fire[d]        = 1'b1;
      end else if (!levelQ[d]) begin
        stateNext[d]   = IDLE;
        holdCntNext[d] = '0;
      end else begin
        case (state[d])
          DELAY: begin
            if (holdCnt[d] == RD_LAST) begin
              stateNext[d]   = REPEAT;
              holdCntNext[d] = '0;
              fire[d]        = 1'b1;
            end else begin
              holdCntNext[d] = holdCnt[d] + HW'(1);
            end
          end
          REPEAT: begin
            if (holdCnt[d] == RP_LAST) begin
              holdCntNext[d] = '0;
              fire[d]        = 1'b1;
            end else begin
              holdCntNext[d] = holdCnt[d] + HW'(1);
            end
          end
          default: begin
            stateNext[d]   = IDLE;
            holdCntNext[d] = '0;
          end
        endcase
      end
    end
  end

  // Auto-repeat state and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        state[d]   <= IDLE;
        holdCnt[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        state[d]   <= stateNext[d];
        holdCnt[d] <= holdCntNext[d];
      end
    end
  end

  assign upRepeatState   = state[0];
  assign downRepeatState = state[1];

  // Cursor next value. Illegal codes recover to seconds. A reset press
  // freezes the cursor, and opposing presses in the same cycle cancel.
  always_comb begin
    cursorNext = cursorPos;
    if (!(cursorPos inside {3'b001, 3'b010, 3'b100})) begin
      cursorNext = 3'b001;
    end else if (!pressQ[IDX_RESET]) begin
      if (pressQ[IDX_LEFT] && !pressQ[IDX_RIGHT]) begin
        cursorNext = {cursorPos[1:0], cursorPos[2]};
      end else if (pressQ[IDX_RIGHT] && !pressQ[IDX_LEFT]) begin
        cursorNext = {cursorPos[0], cursorPos[2:1]};
      end
    end
  end

  // Registered command strobes and cursor. A reset press masks up/down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up        <= 1'b0;
      down      <= 1'b0;
      reset     <= 1'b0;
      cursorPos <= 3'b001;
    end else begin
      reset     <= pressQ[IDX_RESET];
      up        <= fire[0] & ~pressQ[IDX_RESET];
      down      <= fire[1] & ~pressQ[IDX_RESET];
      cursorPos <= cursorNext;
    end
  end

endmodule
